// File: rtl/billiard_pkg.sv
// Shared types and constants for the billiard collision event path.
package billiard_pkg;

  localparam int EVT_ID_W       = 4;
  localparam int NUM_WALL_CODES = 4;
  localparam logic [1:0] WALL_NONE = 2'd0;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_HOLE = 2'd1,
    EVT_BALL = 2'd2,
    EVT_WALL = 2'd3
  } evt_type_t;

  typedef struct packed {
    evt_type_t             etype;
    logic [EVT_ID_W-1:0]   id_a;
    logic [EVT_ID_W-1:0]   id_b;
  } coll_evt_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO of collision events; a pop in the same cycle frees room for a push when full.
module evt_fifo
  import billiard_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  coll_evt_t push_data,
  input  logic      pop,
  output coll_evt_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  coll_evt_t      mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_pop;
  logic           do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Unfilled slots hold stale data, so the head is forced to zero whenever empty.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/collision_event_scheduler.sv
// Turns per-pixel drawing-request overlaps into a deduplicated stream of collision events,
// at most one per object pair per frame, buffered behind a valid/ready FIFO.
module collision_event_scheduler
  import billiard_pkg::*;
#(
  parameter int NUM_BALLS  = 3,
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 new_rack,
  input  logic [NUM_BALLS-1:0] Balls_DR_VEC,
  input  logic [1:0]           Table_DR,
  input  logic                 Hole_DR,
  input  logic [2:0]           Hole_ID,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [1:0]           evt_type,
  output logic [ID_W-1:0]      evt_id_a,
  output logic [ID_W-1:0]      evt_id_b,
  output logic [NUM_BALLS-1:0] balls_in_game,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     frame_evt_count,
  output logic                 frame_overflow
);

  localparam int BIDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

  state_t                                   state;
  logic [NUM_BALLS-1:0]                     live;
  logic [NUM_BALLS-1:0]                     hole_seen;
  logic [NUM_BALLS-1:0][NUM_BALLS-1:0]      pair_seen;
  logic [NUM_BALLS-1:0][NUM_WALL_CODES-1:0] wall_seen;
  logic [BIDX_W-1:0]                        lo_idx;
  logic [BIDX_W-1:0]                        nx_idx;
  logic [1:0]                               n_live;
  logic                                     evt_hit;
  coll_evt_t                                new_evt;
  logic                                     cap_valid;
  coll_evt_t                                cap_evt;
  logic [BIDX_W-1:0]                        cap_ball;
  logic                                     fifo_full;
  logic                                     fifo_empty;
  logic                                     pop;
  logic                                     wr_ok;
  logic                                     wr_drop;
  coll_evt_t                                head;
  logic [CNT_W-1:0]                         evt_cnt;
  logic [CNT_W-1:0]                         evt_cnt_next;
  logic                                     frame_ovf;

  always_comb begin
    live   = Balls_DR_VEC & balls_in_game;
    lo_idx = '0;
    nx_idx = '0;
    n_live = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (live[i]) begin
        if (n_live == 2'd0)      lo_idx = BIDX_W'(i);
        else if (n_live == 2'd1) nx_idx = BIDX_W'(i);
        if (n_live != 2'd2)      n_live = n_live + 2'd1;
      end
    end
  end

  // Already-seen candidates fall through to the next priority, so one pixel can yield
  // a pair event right after its hole event was recorded.
  always_comb begin
    evt_hit = 1'b0;
    new_evt = '0;
    if (state == COLLECT && !startOfFrame && live != '0) begin
      if (Hole_DR && !hole_seen[lo_idx]) begin
        evt_hit       = 1'b1;
        new_evt.etype = EVT_HOLE;
        new_evt.id_a  = EVT_ID_W'(lo_idx);
        new_evt.id_b  = EVT_ID_W'(Hole_ID);
      end else if (n_live == 2'd2 && !pair_seen[lo_idx][nx_idx]) begin
        evt_hit       = 1'b1;
        new_evt.etype = EVT_BALL;
        new_evt.id_a  = EVT_ID_W'(lo_idx);
        new_evt.id_b  = EVT_ID_W'(nx_idx);
      end else if (Table_DR != WALL_NONE && !wall_seen[lo_idx][Table_DR]) begin
        evt_hit       = 1'b1;
        new_evt.etype = EVT_WALL;
        new_evt.id_a  = EVT_ID_W'(lo_idx);
        new_evt.id_b  = EVT_ID_W'(Table_DR);
      end
    end
  end

  assign evt_valid    = !fifo_empty;
  assign pop          = evt_valid && evt_ready;
  assign wr_ok        = cap_valid && (!fifo_full || pop);
  assign wr_drop      = cap_valid && !wr_ok;
  assign evt_cnt_next = (wr_ok && evt_cnt != '1) ? evt_cnt + CNT_W'(1) : evt_cnt;
  assign evt_type     = head.etype;
  assign evt_id_a     = ID_W'(head.id_a);
  assign evt_id_b     = ID_W'(head.id_b);

  evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (cap_valid),
    .push_data(cap_evt),
    .pop      (pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A pocketed ball leaves play as its event leaves the capture stage, one pixel after detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      hole_seen       <= '0;
      pair_seen       <= '0;
      wall_seen       <= '0;
      cap_valid       <= 1'b0;
      cap_evt         <= '0;
      cap_ball        <= '0;
      balls_in_game   <= '1;
      evt_cnt         <= '0;
      frame_ovf       <= 1'b0;
      frame_done      <= 1'b0;
      frame_evt_count <= '0;
      frame_overflow  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cap_valid  <= evt_hit;
      cap_evt    <= new_evt;
      cap_ball   <= lo_idx;
      evt_cnt    <= evt_cnt_next;
      frame_ovf  <= frame_ovf | wr_drop;
      if (evt_hit) begin
        case (new_evt.etype)
          EVT_HOLE: hole_seen[lo_idx]           <= 1'b1;
          EVT_BALL: pair_seen[lo_idx][nx_idx]   <= 1'b1;
          EVT_WALL: wall_seen[lo_idx][Table_DR] <= 1'b1;
          default:  ;
        endcase
      end
      if (cap_valid && cap_evt.etype == EVT_HOLE) balls_in_game[cap_ball] <= 1'b0;
      if (new_rack) balls_in_game <= '1;
      if (startOfFrame) begin
        state     <= COLLECT;
        hole_seen <= '0;
        pair_seen <= '0;
        wall_seen <= '0;
        evt_cnt   <= '0;
        frame_ovf <= 1'b0;
        if (state == COLLECT) begin
          frame_done      <= 1'b1;
          frame_evt_count <= evt_cnt_next;
          frame_overflow  <= frame_ovf | wr_drop;
        end
      end
    end
  end

endmodule

// File: tb/tb_collision_event_scheduler.sv
// Directed bench for collision_event_scheduler; expected events go into a queue when the
// pixels are driven and are compared as each head event is handed over.
module tb_collision_event_scheduler;
  import billiard_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       new_rack = 1'b0;
  logic [2:0] Balls_DR_VEC = '0;
  logic [1:0] Table_DR = '0;
  logic       Hole_DR = 1'b0;
  logic [2:0] Hole_ID = '0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_type;
  logic [3:0] evt_id_a;
  logic [3:0] evt_id_b;
  logic [2:0] balls_in_game;
  logic       frame_done;
  logic [3:0] frame_evt_count;
  logic       frame_overflow;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  collision_event_scheduler #(
    .NUM_BALLS(3), .ID_W(4), .FIFO_DEPTH(8), .CNT_W(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .new_rack       (new_rack),
    .Balls_DR_VEC   (Balls_DR_VEC),
    .Table_DR       (Table_DR),
    .Hole_DR        (Hole_DR),
    .Hole_ID        (Hole_ID),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_type       (evt_type),
    .evt_id_a       (evt_id_a),
    .evt_id_b       (evt_id_b),
    .balls_in_game  (balls_in_game),
    .frame_done     (frame_done),
    .frame_evt_count(frame_evt_count),
    .frame_overflow (frame_overflow)
  );

  function automatic logic [9:0] mkEvt(input logic [1:0] t, input logic [3:0] a, input logic [3:0] b);
    return {t, a, b};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  task automatic applyStimulus(input logic sof, input logic rack, input logic [2:0] balls,
                               input logic [1:0] tbl, input logic hole, input logic [2:0] hid);
    startOfFrame = sof;
    new_rack     = rack;
    Balls_DR_VEC = balls;
    Table_DR     = tbl;
    Hole_DR      = hole;
    Hole_ID      = hid;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 3'd0);
  endtask

  task automatic waitDrain();
    int budget = 60;
    while ((exp_q.size() != 0 || evt_valid) && budget > 0) begin
      idle();
      budget--;
    end
    checkOutput("drain_left", exp_q.size(), 0);
    checkOutput("drain_valid", evt_valid, 0);
  endtask

  task automatic checkFrame(input string tag, input logic [3:0] cnt, input logic ovf);
    checkOutput({tag, "_done"}, frame_done, 1);
    checkOutput({tag, "_count"}, frame_evt_count, cnt);
    checkOutput({tag, "_ovf"}, frame_overflow, ovf);
  endtask

  // Handshakes are judged at the falling edge, so the head seen here is the one popped next edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0)
          checkOutput("spurious_evt", 32'({evt_type, evt_id_a, evt_id_b}), 32'd0);
        else
          checkOutput("evt_order", 32'({evt_type, evt_id_a, evt_id_b}), 32'(exp_q.pop_front()));
      end else if (!evt_valid) begin
        checkOutput("idle_type", evt_type, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_balls", balls_in_game, 3'b111);
    checkOutput("rst_valid", evt_valid, 0);
    checkOutput("rst_type", evt_type, 0);
    checkOutput("rst_done", frame_done, 0);
    checkOutput("rst_count", frame_evt_count, 0);
    checkOutput("rst_ovf", frame_overflow, 0);

    $display("[TB] two-cycle overlap");
    evt_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 3'd0);
    exp_q.push_back(mkEvt(EVT_BALL, 4'd0, 4'd1));
    applyStimulus(1'b0, 1'b0, 3'b011, 2'd0, 1'b0, 3'd0);
    checkOutput("ovl_valid_early", evt_valid, 0);
    applyStimulus(1'b0, 1'b0, 3'b011, 2'd0, 1'b0, 3'd0);
    checkOutput("ovl_valid_2cyc", evt_valid, 1);
    checkOutput("ovl_type", evt_type, EVT_BALL);
    repeat (3) idle();
    checkOutput("ovl_single", evt_valid, 0);
    applyStimulus(1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 3'd0);
    checkFrame("ovl_frame", 4'd1, 1'b0);

    $display("[TB] hole capture");
    exp_q.push_back(mkEvt(EVT_HOLE, 4'd2, 4'd5));
    applyStimulus(1'b0, 1'b0, 3'b100, 2'd0, 1'b1, 3'd5);
    repeat (2) idle();
    checkOutput("hole_balls", balls_in_game, 3'b011);
    applyStimulus(1'b0, 1'b0, 3'b100, 2'd2, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b0, 3'b100, 2'd3, 1'b0, 3'd0);
    applyStimulus(1'b0, 1'b0, 3'b100, 2'd1, 1'b1, 3'd4);
    repeat (3) idle();
    checkOutput("hole_masked", evt_valid, 0);
    applyStimulus(1'b0, 1'b1, 3'b000, 2'd0, 1'b0, 3'd0);
    checkOutput("rack_restore", balls_in_game, 3'b111);

    $display("[TB] priority");
    applyStimulus(1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 3'd0);
    checkFrame("hole_frame", 4'd1, 1'b0);
    exp_q.push_back(mkEvt(EVT_HOLE, 4'd1, 4'd3));
    exp_q.push_back(mkEvt(EVT_BALL, 4'd1, 4'd2));
    applyStimulus(1'b0, 1'b0, 3'b110, 2'd2, 1'b1, 3'd3);
    applyStimulus(1'b0, 1'b0, 3'b110, 2'd2, 1'b1, 3'd3);
    repeat (3) idle();
    checkOutput("prio_balls", balls_in_game, 3'b101);
    checkOutput("prio_left", exp_q.size(), 0);
    applyStimulus(1'b0, 1'b1, 3'b000, 2'd0, 1'b0, 3'd0);
    checkOutput("prio_rack", balls_in_game, 3'b111);
    exp_q.push_back(mkEvt(EVT_HOLE, 4'd0, 4'd7));
    applyStimulus(1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 3'd7);
    applyStimulus(1'b0, 1'b1, 3'b000, 2'd0, 1'b0, 3'd0);
    checkOutput("rack_wins", balls_in_game, 3'b111);
    idle();
    checkOutput("rack_wins_hold", balls_in_game, 3'b111);
    waitDrain();

    $display("[TB] overflow");
    applyStimulus(1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 3'd0);
    checkFrame("prio_frame", 4'd3, 1'b0);
    evt_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int w = 1; w <= 3; w++) begin
        if (!(b == 2 && w == 3)) exp_q.push_back(mkEvt(EVT_WALL, 4'(b), 4'(w)));
        applyStimulus(1'b0, 1'b0, 3'(1 << b), 2'(w), 1'b0, 3'd0);
      end
    end
    repeat (2) idle();
    checkOutput("ovf_head_valid", evt_valid, 1);
    applyStimulus(1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 3'd0);
    checkFrame("ovf_frame", 4'd8, 1'b1);
    evt_ready = 1'b1;
    waitDrain();

    $display("[TB] full with simultaneous pop");
    evt_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int w = 1; w <= 3; w++) begin
        exp_q.push_back(mkEvt(EVT_WALL, 4'(b), 4'(w)));
        applyStimulus(1'b0, 1'b0, 3'(1 << b), 2'(w), 1'b0, 3'd0);
      end
    end
    evt_ready = 1'b1;
    waitDrain();
    applyStimulus(1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 3'd0);
    checkFrame("popfull_frame", 4'd9, 1'b0);

    $display("[TB] mid-frame reset");
    evt_ready = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      exp_q.push_back(mkEvt(EVT_WALL, 4'd0, 4'(w)));
      applyStimulus(1'b0, 1'b0, 3'b001, 2'(w), 1'b0, 3'd0);
    end
    idle();
    checkOutput("rst_fifo_loaded", evt_valid, 1);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    exp_q.delete();
    checkOutput("midrst_valid", evt_valid, 0);
    checkOutput("midrst_type", evt_type, 0);
    checkOutput("midrst_count", frame_evt_count, 0);
    checkOutput("midrst_balls", balls_in_game, 3'b111);
    evt_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b011, 2'd1, 1'b1, 3'd2);
    repeat (3) idle();
    checkOutput("idle_ignored", evt_valid, 0);
    applyStimulus(1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 3'd0);
    exp_q.push_back(mkEvt(EVT_BALL, 4'd0, 4'd1));
    applyStimulus(1'b0, 1'b0, 3'b011, 2'd0, 1'b0, 3'd0);
    waitDrain();
    applyStimulus(1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 3'd0);
    checkFrame("final_frame", 4'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
